// File: rtl/teacher_streamer_if.sv
// Teacher-vector handshake bus between the teacher streamer and the output layer.
// Valid/ready: a transfer happens on every rising edge where both are high; once the
// master raises valid it holds valid, data and index steady until that transfer.
interface teacher_streamer_if #(
    parameter int DW = 54,
    parameter int AW = 4
);
    logic          oValid_BM_Teacher;
    logic          iReady_BM_Teacher;
    logic [DW-1:0] oData_BM_Teacher;
    logic [AW-1:0] oIndex;

    modport master (
        output oValid_BM_Teacher,
        output oData_BM_Teacher,
        output oIndex,
        input  iReady_BM_Teacher
    );

    modport slave (
        input  oValid_BM_Teacher,
        input  oData_BM_Teacher,
        input  oIndex,
        output iReady_BM_Teacher
    );
endinterface

// File: rtl/teacher_streamer.sv
// Streams host-loaded teacher vectors, one per sample in index order, into the output
// layer's Teacher input; wraps at the last sample and counts completed epochs.
module teacher_streamer #(
    parameter int    NP    = 7,
    parameter int    NC    = 6,
    parameter int    WF    = 5,
    parameter int    NS    = 16,
    parameter string BURST = "yes",
    localparam int   WD    = $clog2(NP) + 1 + WF,
    localparam int   DW    = NC * WD,
    localparam int   AW    = $clog2(NS)
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iMode,
    input  logic          iStart,
    input  logic [AW-1:0] iLast,
    input  logic          iWe,
    input  logic [AW-1:0] iWaddr,
    input  logic [DW-1:0] iWdata,
    teacher_streamer_if.master tx,
    output logic [15:0]   oEpoch,
    output logic          oBusy,
    output logic [1:0]    oState
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;
    localparam bit BURST_EN = (BURST == "yes");

    logic [DW-1:0] mem_q [NS];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] last_q, last_d;
    logic [15:0]   epoch_q, epoch_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] index_q, index_d;

    logic          hs;
    logic [AW-1:0] nxt;
    logic [AW-1:0] last_clamped;

    assign hs           = valid_q & tx.iReady_BM_Teacher;
    assign nxt          = (ptr_q == last_q) ? '0 : ptr_q + 1'b1;
    assign last_clamped = (32'(iLast) > NS - 1) ? AW'(NS - 1) : iLast;

    // Storage has no reset so a mid-stream reset leaves the loaded dataset intact.
    always_ff @(posedge iCLK) begin
        if (iWe) mem_q[iWaddr] <= iWdata;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        epoch_d = epoch_q;
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
        case (state_q)
            S_IDLE: begin
                if (iStart && iMode) begin
                    ptr_d   = '0;
                    epoch_d = '0;
                    last_d  = last_clamped;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                data_d  = mem_q[ptr_q];
                index_d = ptr_q;
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (hs) begin
                    ptr_d = nxt;
                    if (ptr_q == last_q && epoch_q != 16'hFFFF) epoch_d = epoch_q + 16'd1;
                    // A pending vector always completes before a mode drop takes effect.
                    if (!iMode) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end else if (BURST_EN) begin
                        data_d  = mem_q[nxt];
                        index_d = nxt;
                    end else begin
                        valid_d = 1'b0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (!iMode) begin
                    state_d = S_IDLE;
                end else begin
                    data_d  = mem_q[ptr_q];
                    index_d = ptr_q;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            last_q  <= '0;
            epoch_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            epoch_q <= epoch_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
        end
    end

    assign tx.oValid_BM_Teacher = valid_q;
    assign tx.oData_BM_Teacher  = data_q;
    assign tx.oIndex            = index_q;
    assign oEpoch               = epoch_q;
    assign oBusy                = (state_q != S_IDLE);
    assign oState               = state_q;
endmodule

// File: tb/tb_teacher_streamer.sv
// Bench for teacher_streamer: a burst and a non-burst instance share the host-side
// inputs; transfers are checked against a sample-index model of the teacher memory.
module tb_teacher_streamer;
    localparam int NP = 7;
    localparam int NC = 6;
    localparam int WF = 5;
    localparam int NS = 16;
    localparam int WD = $clog2(NP) + 1 + WF;
    localparam int DW = NC * WD;
    localparam int AW = $clog2(NS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] last = '0;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic          ready = 1'b0;

    logic [15:0] epoch_y, epoch_n;
    logic        busy_y, busy_n;
    logic [1:0]  state_y, state_n;

    int checks = 0;
    int errs = 0;

    logic [DW-1:0] ref_mem [NS];
    logic [DW-1:0] exp_q [$];

    teacher_streamer_if #(.DW(DW), .AW(AW)) bus_y ();
    teacher_streamer_if #(.DW(DW), .AW(AW)) bus_n ();
    assign bus_y.iReady_BM_Teacher = ready;
    assign bus_n.iReady_BM_Teacher = ready;

    teacher_streamer #(.NP(NP), .NC(NC), .WF(WF), .NS(NS), .BURST("yes")) dut_y (
        .iCLK(clk), .iRST(rst_n), .iMode(mode), .iStart(start), .iLast(last),
        .iWe(we), .iWaddr(waddr), .iWdata(wdata), .tx(bus_y),
        .oEpoch(epoch_y), .oBusy(busy_y), .oState(state_y)
    );

    teacher_streamer #(.NP(NP), .NC(NC), .WF(WF), .NS(NS), .BURST("no")) dut_n (
        .iCLK(clk), .iRST(rst_n), .iMode(mode), .iStart(start), .iLast(last),
        .iWe(we), .iWaddr(waddr), .iWdata(wdata), .tx(bus_n),
        .oEpoch(epoch_n), .oBusy(busy_n), .oState(state_n)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_mem(input int k, input logic [DW-1:0] d);
        we = 1'b1;
        waddr = AW'(k);
        wdata = d;
        cyc();
        we = 1'b0;
        ref_mem[k] = d;
    endtask

    task automatic pulse_start(input int l);
        last = AW'(l);
        mode = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_valid_y();
        for (int i = 0; i < 20 && !bus_y.oValid_BM_Teacher; i++) cyc();
        chk("wait_valid_y", 64'(bus_y.oValid_BM_Teacher), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && (busy_y || busy_n); i++) cyc();
        chk("wait_idle", {62'd0, busy_y, busy_n}, 64'd0);
    endtask

    // Sample n of a stream over samples 0..L is sample n mod (L+1).
    function automatic int exp_idx(input int n, input int l);
        return n % (l + 1);
    endfunction

    initial begin
        int n;
        int l;
        logic hold;
        logic [DW-1:0] hold_data;
        logic [AW-1:0] hold_idx;
        logic [DW-1:0] old_d;
        logic [DW-1:0] new_d;
        logic [WD-1:0] chan;

        // Reset state.
        cyc();
        chk("rst_valid", 64'(bus_y.oValid_BM_Teacher), 64'd0);
        chk("rst_data",  64'(bus_y.oData_BM_Teacher), 64'd0);
        chk("rst_index", 64'(bus_y.oIndex), 64'd0);
        chk("rst_epoch", 64'(epoch_y), 64'd0);
        chk("rst_busy",  64'(busy_y), 64'd0);
        rst_n = 1'b1;
        cyc();

        for (int k = 0; k < NS; k++) begin
            if (k < 4) begin
                chan = WD'(k + 1);
                write_mem(k, {NC{chan}});
            end else begin
                write_mem(k, DW'({$urandom, $urandom}));
            end
        end

        // Burst streaming, wrap at sample 3, start pulse while busy ignored.
        ready = 1'b1;
        pulse_start(3);
        chk("t2_lat1_valid", 64'(bus_y.oValid_BM_Teacher), 64'd0);
        chk("t2_lat1_busy", 64'(busy_y), 64'd1);
        cyc();
        chk("t2_lat2_valid", 64'(bus_y.oValid_BM_Teacher), 64'd1);
        for (int i = 0; i < 12; i++) begin
            chk("t2_valid", 64'(bus_y.oValid_BM_Teacher), 64'd1);
            chk("t2_index", 64'(bus_y.oIndex), 64'(exp_idx(i, 3)));
            chk("t2_data", 64'(bus_y.oData_BM_Teacher), 64'(ref_mem[exp_idx(i, 3)]));
            chk("t2_epoch", 64'(epoch_y), 64'(i / 4));
            start = (i == 5);
            last = (i == 5) ? AW'(7) : AW'(3);
            cyc();
        end
        start = 1'b0;
        last = AW'(3);
        mode = 1'b0;
        wait_idle();

        // Non-burst: one transfer every other cycle.
        pulse_start(3);
        for (int i = 0; i < 20 && !bus_n.oValid_BM_Teacher; i++) cyc();
        n = 0;
        for (int c = 0; c < 16; c++) begin
            chk("t3_valid_pattern", 64'(bus_n.oValid_BM_Teacher), 64'((c % 2) == 0));
            if (bus_n.oValid_BM_Teacher && ready) begin
                chk("t3_index", 64'(bus_n.oIndex), 64'(exp_idx(n, 3)));
                chk("t3_data", 64'(bus_n.oData_BM_Teacher), 64'(ref_mem[exp_idx(n, 3)]));
                n++;
            end
            cyc();
        end
        chk("t3_count", 64'(n), 64'd8);
        mode = 1'b0;
        wait_idle();

        // Random ready, random dataset size.
        l = $urandom_range(4, NS - 1);
        ready = 1'b0;
        pulse_start(l);
        n = 0;
        hold = 1'b0;
        hold_data = '0;
        hold_idx = '0;
        for (int c = 0; c < 3000 && n < 100; c++) begin
            cyc();
            if (hold) begin
                chk("t4_hold_data", 64'(bus_y.oData_BM_Teacher), 64'(hold_data));
                chk("t4_hold_index", 64'(bus_y.oIndex), 64'(hold_idx));
            end
            ready = 1'($urandom_range(0, 1));
            if (bus_y.oValid_BM_Teacher && ready) begin
                exp_q.push_back(ref_mem[exp_idx(n, l)]);
                chk("t4_index", 64'(bus_y.oIndex), 64'(exp_idx(n, l)));
                chk("t4_data", 64'(bus_y.oData_BM_Teacher), 64'(exp_q.pop_front()));
                n++;
            end
            hold = bus_y.oValid_BM_Teacher && !ready;
            hold_data = bus_y.oData_BM_Teacher;
            hold_idx = bus_y.oIndex;
        end
        chk("t4_count", 64'(n), 64'd100);
        cyc();
        ready = 1'b0;
        chk("t4_epoch", 64'(epoch_y), 64'(100 / (l + 1)));

        // Mode drop while a vector waits: it still completes, then the streamer idles.
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_wait_valid", 64'(bus_y.oValid_BM_Teacher), 64'd1);
            chk("t5_wait_index", 64'(bus_y.oIndex), 64'(exp_idx(n, l)));
        end
        ready = 1'b1;
        cyc();
        chk("t5_after_valid", 64'(bus_y.oValid_BM_Teacher), 64'd0);
        chk("t5_after_busy", 64'(busy_y), 64'd0);
        chk("t5_after_epoch", 64'(epoch_y), 64'((n + 1) / (l + 1)));
        wait_idle();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("t5_nomode_busy", 64'(busy_y), 64'd0);
        chk("t5_nomode_valid", 64'(bus_y.oValid_BM_Teacher), 64'd0);

        // Single-sample dataset: epoch per transfer, write lands on the next vector.
        ready = 1'b1;
        pulse_start(0);
        wait_valid_y();
        for (int i = 0; i < 5; i++) begin
            chk("t6_index", 64'(bus_y.oIndex), 64'd0);
            chk("t6_data", 64'(bus_y.oData_BM_Teacher), 64'(ref_mem[0]));
            chk("t6_epoch", 64'(epoch_y), 64'(i));
            cyc();
        end
        ready = 1'b0;
        chk("t6_epoch5", 64'(epoch_y), 64'd5);
        old_d = ref_mem[0];
        new_d = DW'({$urandom, $urandom}) ^ old_d ^ DW'(1);
        write_mem(0, new_d);
        chk("t6_latched_unchanged", 64'(bus_y.oData_BM_Teacher), 64'(old_d));
        ready = 1'b1;
        cyc();
        chk("t6_new_data", 64'(bus_y.oData_BM_Teacher), 64'(new_d));
        chk("t6_epoch6", 64'(epoch_y), 64'd6);
        force dut_y.epoch_q = 16'hFFFE;
        #1;
        release dut_y.epoch_q;
        cyc();
        chk("t6_epoch_top", 64'(epoch_y), 64'hFFFF);
        cyc();
        chk("t6_epoch_sat", 64'(epoch_y), 64'hFFFF);
        cyc();
        chk("t6_epoch_sat2", 64'(epoch_y), 64'hFFFF);

        // Asynchronous reset mid-stream, then restart over the preserved memory.
        rst_n = 1'b0;
        #1;
        chk("t1_valid", 64'(bus_y.oValid_BM_Teacher), 64'd0);
        chk("t1_data", 64'(bus_y.oData_BM_Teacher), 64'd0);
        chk("t1_index", 64'(bus_y.oIndex), 64'd0);
        chk("t1_epoch", 64'(epoch_y), 64'd0);
        chk("t1_busy", 64'(busy_y), 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        pulse_start(3);
        wait_valid_y();
        for (int i = 0; i < 4; i++) begin
            chk("t1_restart_index", 64'(bus_y.oIndex), 64'(i));
            chk("t1_restart_data", 64'(bus_y.oData_BM_Teacher), 64'(ref_mem[i]));
            cyc();
        end
        mode = 1'b0;
        ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
